hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/hilo_unit_if.sv | 31 +++
 rtl/hilo_regfile.sv | 40 ++++
 rtl/hilo_unit.sv | 102 ++++++++++
 tb/tb_hilo_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide datapath blocks.
//   CNT_W       : width of the multiply latency down-counter
//   cnt_t       : counter type
//   mul_state_e : HI/LO control state encoding (IDLE / BUSY)
package muldiv_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/hilo_unit_if.sv
// Request/response bundle of the HI/LO unit.
//   requests  : mul_start, prod_in[63:0], mthi, mtlo, wdata[31:0], mfhi, mflo
//   responses : rdata[31:0], rvalid, stall, busy, hi[31:0], lo[31:0]
// master = requester side, slave = hilo_unit side.
interface hilo_unit_if;

  logic        mul_start;
  logic [63:0] prod_in;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        mfhi;
  logic        mflo;
  logic [31:0] rdata;
  logic        rvalid;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output mul_start, prod_in, mthi, mtlo, wdata, mfhi, mflo,
    input  rdata, rvalid, stall, busy, hi, lo
  );

  modport slave (
    input  mul_start, prod_in, mthi, mtlo, wdata, mfhi, mflo,
    output rdata, rvalid, stall, busy, hi, lo
  );

endinterface

// File: rtl/hilo_regfile.sv
// HI/LO architectural registers with independent write enables.
//   clk, reset     : clock, asynchronous active-high reset (clears both)
//   hi_we, hi_wd   : HI write enable / data
//   lo_we, lo_wd   : LO write enable / data
//   hi, lo         : current register contents
module hilo_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_we,
  input  logic [31:0] hi_wd,
  input  logic        lo_we,
  input  logic [31:0] lo_wd,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hi_we) hi_d = hi_wd;
    if (lo_we) lo_d = lo_wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO unit: sequences multiplier result capture into HI/LO and serves
// mthi/mtlo writes and mfhi/mflo reads.
//   MUL_LATENCY : edges from mul_start acceptance to product capture (1..15)
//   clk, reset  : clock, asynchronous active-high reset
//   bus (slave) : requests in, registered read data / status out
// While a multiply is in flight every request is stalled and must be held.
module hilo_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  hilo_unit_if.slave  bus
);

  mul_state_e  state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic        hi_we, lo_we;
  logic [31:0] hi_wd, lo_wd;
  logic [31:0] hi_r, lo_r;
  logic        any_req;

  assign any_req = bus.mul_start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_wd    = bus.wdata;
    lo_wd    = bus.wdata;
    case (state_q)
      ST_IDLE: begin
        hi_we = bus.mthi;
        lo_we = bus.mtlo;
        // Reads sample the register outputs, i.e. the value before any
        // same-cycle write lands.
        if (bus.mfhi) begin
          rdata_d  = hi_r;
          rvalid_d = 1'b1;
        end else if (bus.mflo) begin
          rdata_d  = lo_r;
          rvalid_d = 1'b1;
        end
        if (bus.mul_start) begin
          state_d = ST_BUSY;
          cnt_d   = cnt_t'(MUL_LATENCY);
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == cnt_t'(1)) begin
          state_d = ST_IDLE;
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          hi_wd   = bus.prod_in[63:32];
          lo_wd   = bus.prod_in[31:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  hilo_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .hi_we (hi_we),
    .hi_wd (hi_wd),
    .lo_we (lo_we),
    .lo_wd (lo_wd),
    .hi    (hi_r),
    .lo    (lo_r)
  );

  assign bus.busy   = (state_q == ST_BUSY);
  assign bus.stall  = (state_q == ST_BUSY) & any_req;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.hi     = hi_r;
  assign bus.lo     = lo_r;

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_unit_if bus4();
  hilo_unit_if bus1();

  hilo_unit #(.MUL_LATENCY(LAT)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  hilo_unit #(.MUL_LATENCY(1))   dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr4();
    bus4.mul_start = 1'b0; bus4.mthi = 1'b0; bus4.mtlo = 1'b0;
    bus4.mfhi = 1'b0; bus4.mflo = 1'b0; bus4.wdata = '0; bus4.prod_in = '0;
  endtask

  typedef struct {
    logic        wh, wl, rh, rl;
    logic [31:0] wd;
    logic        e_rv;
    logic [31:0] e_rd, e_hi, e_lo;
  } vec_t;

  vec_t vt[10];

  // Behavioural reference: cycle numbers instead of a counter.
  int          m_edge, m_cap;
  logic [31:0] m_hi, m_lo, m_rd;
  logic        m_rv;

  initial begin
    reset = 1'b1;
    clr4();
    bus1.mul_start = 1'b0; bus1.mthi = 1'b0; bus1.mtlo = 1'b0;
    bus1.mfhi = 1'b0; bus1.mflo = 1'b0; bus1.wdata = '0; bus1.prod_in = '0;

    //                wh  wl  rh  rl  wd            rv  rd            hi            lo
    vt[0] = '{1'b1,1'b0,1'b0,1'b0,32'hAAAA_0001, 1'b0,32'h0,         32'hAAAA_0001,32'h0};
    vt[1] = '{1'b0,1'b1,1'b0,1'b0,32'h5555_0002, 1'b0,32'h0,         32'hAAAA_0001,32'h5555_0002};
    vt[2] = '{1'b0,1'b0,1'b1,1'b0,32'h0,         1'b1,32'hAAAA_0001, 32'hAAAA_0001,32'h5555_0002};
    vt[3] = '{1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'hAAAA_0001, 32'hAAAA_0001,32'h5555_0002};
    vt[4] = '{1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h5555_0002, 32'hAAAA_0001,32'h5555_0002};
    vt[5] = '{1'b0,1'b0,1'b1,1'b1,32'h0,         1'b1,32'hAAAA_0001, 32'hAAAA_0001,32'h5555_0002};
    vt[6] = '{1'b1,1'b1,1'b0,1'b0,32'h1234_5678, 1'b0,32'hAAAA_0001, 32'h1234_5678,32'h1234_5678};
    vt[7] = '{1'b0,1'b1,1'b0,1'b1,32'hCAFE_F00D, 1'b1,32'h1234_5678, 32'h1234_5678,32'hCAFE_F00D};
    vt[8] = '{1'b1,1'b0,1'b1,1'b0,32'hDEAD_BEEF, 1'b1,32'h1234_5678, 32'hDEAD_BEEF,32'hCAFE_F00D};
    vt[9] = '{1'b0,1'b0,1'b1,1'b0,32'h0,         1'b1,32'hDEAD_BEEF, 32'hDEAD_BEEF,32'hCAFE_F00D};

    // Reset state
    tick(); tick();
    bus4.mfhi = 1'b1;
    #1;
    chk("rst_hi", bus4.hi, 0);
    chk("rst_lo", bus4.lo, 0);
    chk("rst_rdata", bus4.rdata, 0);
    chk("rst_rvalid", bus4.rvalid, 0);
    chk("rst_busy", bus4.busy, 0);
    chk("rst_stall", bus4.stall, 0);
    chk("rst_busy1", bus1.busy, 0);
    bus4.mfhi = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle-mode table
    for (int i = 0; i < 10; i++) begin
      bus4.mthi = vt[i].wh; bus4.mtlo = vt[i].wl;
      bus4.mfhi = vt[i].rh; bus4.mflo = vt[i].rl; bus4.wdata = vt[i].wd;
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), bus4.stall, 0);
      tick();
      chk($sformatf("tbl%0d_rvalid", i), bus4.rvalid, vt[i].e_rv);
      chk($sformatf("tbl%0d_rdata", i), bus4.rdata, vt[i].e_rd);
      chk($sformatf("tbl%0d_hi", i), bus4.hi, vt[i].e_hi);
      chk($sformatf("tbl%0d_lo", i), bus4.lo, vt[i].e_lo);
    end
    clr4();

    // Basic multiply: capture exactly LAT edges after acceptance
    bus4.mul_start = 1'b1; bus4.prod_in = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus4.mul_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mul_busy_c%0d", k), bus4.busy, 1);
      chk($sformatf("mul_hi_hold_c%0d", k), bus4.hi, 32'hDEAD_BEEF);
      if (k == 4) bus4.prod_in = 64'h0000_0002_0000_0003;
      tick();
    end
    chk("mul_hi", bus4.hi, 2);
    chk("mul_lo", bus4.lo, 3);
    chk("mul_busy_end", bus4.busy, 0);

    // Read stalled during multiply, retried after capture
    bus4.mul_start = 1'b1; bus4.prod_in = 64'h1111_2222_3333_4444;
    tick();
    bus4.mul_start = 1'b0;
    tick();
    bus4.mfhi = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("rd_stall_c%0d", k), bus4.stall, 1);
      tick();
      chk($sformatf("rd_rvalid_c%0d", k), bus4.rvalid, 0);
    end
    @(negedge clk);
    chk("rd_stall_idle", bus4.stall, 0);
    chk("rd_busy_idle", bus4.busy, 0);
    tick();
    chk("rd_rvalid", bus4.rvalid, 1);
    chk("rd_rdata", bus4.rdata, 32'h1111_2222);
    bus4.mfhi = 1'b0;
    tick();
    chk("rd_rvalid_drop", bus4.rvalid, 0);
    chk("rd_rdata_hold", bus4.rdata, 32'h1111_2222);

    // Reset mid-multiply discards the capture
    bus4.mul_start = 1'b1; bus4.prod_in = 64'h7777_8888_9999_AAAA;
    tick();
    bus4.mul_start = 1'b0;
    tick();
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", bus4.busy, 0);
    chk("arst_hi", bus4.hi, 0);
    chk("arst_lo", bus4.lo, 0);
    chk("arst_rdata", bus4.rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk($sformatf("arst_hi_c%0d", k), bus4.hi, 0);
      chk($sformatf("arst_lo_c%0d", k), bus4.lo, 0);
      chk($sformatf("arst_busy_c%0d", k), bus4.busy, 0);
    end

    // Back-to-back: second mul_start held through BUSY
    bus4.mul_start = 1'b1; bus4.prod_in = 64'h0000_00A1_0000_00B1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_stall_c%0d", k), bus4.stall, 1);
      tick();
    end
    chk("b2b_hi1", bus4.hi, 32'hA1);
    chk("b2b_lo1", bus4.lo, 32'hB1);
    @(negedge clk);
    chk("b2b_stall_idle", bus4.stall, 0);
    bus4.prod_in = 64'h0000_00A2_0000_00B2;
    tick();
    bus4.mul_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("b2b_busy2_c%0d", k), bus4.busy, 1);
      chk($sformatf("b2b_hi_hold_c%0d", k), bus4.hi, 32'hA1);
      tick();
    end
    chk("b2b_hi2", bus4.hi, 32'hA2);
    chk("b2b_lo2", bus4.lo, 32'hB2);
    chk("b2b_busy_end", bus4.busy, 0);

    // Latency 1 instance
    bus1.mul_start = 1'b1; bus1.prod_in = 64'h0BAD_F00D_1234_ABCD;
    @(negedge clk);
    chk("l1_busy_pre", bus1.busy, 0);
    tick();
    bus1.mul_start = 1'b0;
    chk("l1_busy", bus1.busy, 1);
    chk("l1_hi_pre", bus1.hi, 0);
    tick();
    chk("l1_hi", bus1.hi, 32'h0BAD_F00D);
    chk("l1_lo", bus1.lo, 32'h1234_ABCD);
    chk("l1_busy_end", bus1.busy, 0);

    // Randomized run against the reference model
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_edge = 0; m_cap = -1; m_hi = '0; m_lo = '0; m_rd = '0; m_rv = 1'b0;
    for (int c = 0; c < 300; c++) begin
      logic in_flight, any;
      bus4.mul_start = ($urandom_range(5) == 0);
      bus4.mthi      = ($urandom_range(3) == 0);
      bus4.mtlo      = ($urandom_range(3) == 0);
      bus4.mfhi      = ($urandom_range(3) == 0);
      bus4.mflo      = ($urandom_range(3) == 0);
      bus4.wdata     = $urandom;
      bus4.prod_in   = {$urandom, $urandom};
      in_flight = (m_cap >= m_edge + 1);
      any = bus4.mul_start | bus4.mthi | bus4.mtlo | bus4.mfhi | bus4.mflo;
      @(negedge clk);
      chk("rnd_stall", bus4.stall, in_flight & any);
      chk("rnd_busy", bus4.busy, in_flight);
      m_rv = 1'b0;
      if (in_flight) begin
        if (m_edge + 1 == m_cap) {m_hi, m_lo} = bus4.prod_in;
      end else begin
        if (bus4.mfhi) begin m_rd = m_hi; m_rv = 1'b1; end
        else if (bus4.mflo) begin m_rd = m_lo; m_rv = 1'b1; end
        if (bus4.mthi) m_hi = bus4.wdata;
        if (bus4.mtlo) m_lo = bus4.wdata;
        if (bus4.mul_start) m_cap = m_edge + 1 + int'(LAT);
      end
      tick();
      m_edge++;
      chk("rnd_hi", bus4.hi, m_hi);
      chk("rnd_lo", bus4.lo, m_lo);
      chk("rnd_rvalid", bus4.rvalid, m_rv);
      chk("rnd_rdata", bus4.rdata, m_rd);
    end
    clr4();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
